// File: rtl/mem_access_unit_pkg.sv
// Shared encodings and lane helpers for the MEM-stage data-memory access unit.
// Widths and select encodings match the ID-stage memory control generator.
package mem_access_unit_pkg;

    localparam int unsigned DATA_BUS    = 32;
    localparam int unsigned MEM_SEL_BUS = 4;
    localparam int unsigned LANE_BUS    = 2;

    localparam logic [MEM_SEL_BUS-1:0] MEM_SEL_NONE = 4'b0000;
    localparam logic [MEM_SEL_BUS-1:0] MEM_SEL_BYTE = 4'b0001;
    localparam logic [MEM_SEL_BUS-1:0] MEM_SEL_HALF = 4'b0011;
    localparam logic [MEM_SEL_BUS-1:0] MEM_SEL_WORD = 4'b1111;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    // Access attributes latched at request time for the load return path.
    typedef struct packed {
        logic                   sign;
        logic [MEM_SEL_BUS-1:0] size;
        logic [LANE_BUS-1:0]    lane;
    } acc_ctl_t;

    function automatic logic is_misaligned(input logic [MEM_SEL_BUS-1:0] sel,
                                           input logic [LANE_BUS-1:0]    lane);
        return ((sel == MEM_SEL_HALF) && lane[0]) ||
               ((sel == MEM_SEL_WORD) && (lane != 2'b00));
    endfunction

    function automatic logic [MEM_SEL_BUS-1:0] byte_en(input logic [MEM_SEL_BUS-1:0] sel,
                                                       input logic [LANE_BUS-1:0]    lane);
        case (sel)
            MEM_SEL_BYTE: return 4'b0001 << lane;
            MEM_SEL_HALF: return 4'b0011 << {lane[1], 1'b0};
            MEM_SEL_WORD: return 4'b1111;
            default:      return 4'b0000;
        endcase
    endfunction

    function automatic logic [DATA_BUS-1:0] lane_wdata(input logic [MEM_SEL_BUS-1:0] sel,
                                                       input logic [DATA_BUS-1:0]    data);
        case (sel)
            MEM_SEL_BYTE: return {4{data[7:0]}};
            MEM_SEL_HALF: return {2{data[15:0]}};
            MEM_SEL_WORD: return data;
            default:      return '0;
        endcase
    endfunction

endpackage

// File: rtl/mem_access_unit_if.sv
// Request/acknowledge data-RAM port between the access unit (master) and memory (slave).
interface mem_access_unit_if
    import mem_access_unit_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32
);

    logic                   ram_req;
    logic                   ram_we;
    logic [ADDR_WIDTH-1:0]  ram_addr;
    logic [MEM_SEL_BUS-1:0] ram_be;
    logic [DATA_WIDTH-1:0]  ram_wdata;
    logic                   ram_ack;
    logic [DATA_WIDTH-1:0]  ram_rdata;

    modport master (
        output ram_req, ram_we, ram_addr, ram_be, ram_wdata,
        input  ram_ack, ram_rdata
    );

    modport slave (
        input  ram_req, ram_we, ram_addr, ram_be, ram_wdata,
        output ram_ack, ram_rdata
    );

endinterface

// File: rtl/mem_access_unit_load_align.sv
// mem_load_align: picks the addressed byte/half lane out of a read word and
// sign- or zero-extends it; full words pass straight through.
module mem_load_align
    import mem_access_unit_pkg::*;
(
    input  logic [DATA_BUS-1:0]    rdata,
    input  logic [LANE_BUS-1:0]    lane,
    input  logic [MEM_SEL_BUS-1:0] size,
    input  logic                   sign,
    output logic [DATA_BUS-1:0]    load_data_c
);

    logic [7:0]  byte_c;
    logic [15:0] half_c;

    always_comb begin : lane_sel
        byte_c = rdata[7:0];
        case (lane)
            2'd1:    byte_c = rdata[15:8];
            2'd2:    byte_c = rdata[23:16];
            2'd3:    byte_c = rdata[31:24];
            default: byte_c = rdata[7:0];
        endcase
        half_c = lane[1] ? rdata[31:16] : rdata[15:0];
    end

    always_comb begin : extend
        load_data_c = '0;
        case (size)
            MEM_SEL_BYTE: load_data_c = {{24{sign & byte_c[7]}}, byte_c};
            MEM_SEL_HALF: load_data_c = {{16{sign & half_c[15]}}, half_c};
            MEM_SEL_WORD: load_data_c = rdata;
            default:      load_data_c = '0;
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// MEM-stage data-memory access engine: request/ack RAM port, aligned load return, pipeline stall.
// Optional bus timeout enabled by defining MEM_TIMEOUT_EN.
module mem_access_unit
    import mem_access_unit_pkg::*;
#(
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned ADDR_WIDTH     = 32,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   mem_read_flag,
    input  logic                   mem_write_flag,
    input  logic                   mem_sign_flag,
    input  logic [MEM_SEL_BUS-1:0] mem_sel,
    input  logic [DATA_WIDTH-1:0]  mem_write_data,
    input  logic [ADDR_WIDTH-1:0]  mem_addr,
    mem_access_unit_if.master      ram,
    output logic [DATA_WIDTH-1:0]  load_data,
    output logic                   load_valid,
    output logic                   stall_req,
    output logic                   misalign_exc,
    output logic                   bus_err_exc
);

    state_e state_q, state_d;

    logic                   req_q, req_d;
    logic                   we_q, we_d;
    logic [ADDR_WIDTH-1:0]  addr_q, addr_d;
    logic [MEM_SEL_BUS-1:0] be_q, be_d;
    logic [DATA_WIDTH-1:0]  wdata_q, wdata_d;
    acc_ctl_t               ctl_q, ctl_d;
    logic [DATA_WIDTH-1:0]  load_data_q, load_data_d;
    logic                   load_valid_q, load_valid_d;
    logic                   misalign_q, misalign_d;

    logic                   valid_c;
    logic                   misalign_c;
    logic                   start_c;
    logic                   timeout_c;
    logic [DATA_WIDTH-1:0]  aligned_c;

    // A write wins when both read and write are flagged; an empty select is a no-op.
    assign valid_c    = (mem_read_flag | mem_write_flag) & (mem_sel != MEM_SEL_NONE);
    assign misalign_c = valid_c & is_misaligned(mem_sel, mem_addr[1:0]);
    assign start_c    = valid_c & ~misalign_c;

    assign stall_req = rst_n & (((state_q == ST_IDLE) & start_c) | (state_q == ST_REQ));

    mem_load_align u_load_align (
        .rdata       (ram.ram_rdata),
        .lane        (ctl_q.lane),
        .size        (ctl_q.size),
        .sign        (ctl_q.sign),
        .load_data_c (aligned_c)
    );

`ifdef MEM_TIMEOUT_EN
    logic [7:0] tmo_cnt_q;
    logic       bus_err_q;

    // Counts REQ cycles; cleared whenever the FSM is outside REQ, so it restarts on entry.
    always_ff @(posedge clk or negedge rst_n) begin : tmo_cnt_reg
        if (!rst_n) begin
            tmo_cnt_q <= '0;
        end else if (state_q == ST_REQ) begin
            tmo_cnt_q <= tmo_cnt_q + 8'd1;
        end else begin
            tmo_cnt_q <= '0;
        end
    end

    assign timeout_c = (state_q == ST_REQ) & ~ram.ram_ack &
                       (tmo_cnt_q == 8'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or negedge rst_n) begin : bus_err_reg
        if (!rst_n) begin
            bus_err_q <= 1'b0;
        end else begin
            bus_err_q <= timeout_c;
        end
    end

    assign bus_err_exc = bus_err_q;
`else
    assign timeout_c   = 1'b0;
    assign bus_err_exc = 1'b0;

    // REQ waits indefinitely; the timeout depth only matters for the counter build.
    if (TIMEOUT_CYCLES == 0) begin : g_timeout_unused
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin : state_reg
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin : next_state
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (start_c) state_d = ST_REQ;
            ST_REQ:  if (ram.ram_ack || timeout_c) state_d = ST_DONE;
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin : out_comb
        req_d        = req_q;
        we_d         = we_q;
        addr_d       = addr_q;
        be_d         = be_q;
        wdata_d      = wdata_q;
        ctl_d        = ctl_q;
        load_data_d  = load_data_q;
        load_valid_d = 1'b0;
        misalign_d   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start_c) begin
                    req_d   = 1'b1;
                    we_d    = mem_write_flag;
                    addr_d  = {mem_addr[ADDR_WIDTH-1:2], 2'b00};
                    be_d    = byte_en(mem_sel, mem_addr[1:0]);
                    wdata_d = lane_wdata(mem_sel, mem_write_data);
                    ctl_d   = '{sign: mem_sign_flag, size: mem_sel, lane: mem_addr[1:0]};
                end else if (misalign_c) begin
                    misalign_d = 1'b1;
                end
            end
            ST_REQ: begin
                if (ram.ram_ack) begin
                    req_d = 1'b0;
                    if (!we_q) begin
                        load_data_d  = aligned_c;
                        load_valid_d = 1'b1;
                    end
                end else if (timeout_c) begin
                    req_d       = 1'b0;
                    load_data_d = '0;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin : out_reg
        if (!rst_n) begin
            req_q        <= 1'b0;
            we_q         <= 1'b0;
            addr_q       <= '0;
            be_q         <= '0;
            wdata_q      <= '0;
            ctl_q        <= '0;
            load_data_q  <= '0;
            load_valid_q <= 1'b0;
            misalign_q   <= 1'b0;
        end else begin
            req_q        <= req_d;
            we_q         <= we_d;
            addr_q       <= addr_d;
            be_q         <= be_d;
            wdata_q      <= wdata_d;
            ctl_q        <= ctl_d;
            load_data_q  <= load_data_d;
            load_valid_q <= load_valid_d;
            misalign_q   <= misalign_d;
        end
    end

    assign ram.ram_req   = req_q;
    assign ram.ram_we    = we_q;
    assign ram.ram_addr  = addr_q;
    assign ram.ram_be    = be_q;
    assign ram.ram_wdata = wdata_q;
    assign load_data     = load_data_q;
    assign load_valid    = load_valid_q;
    assign misalign_exc  = misalign_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Randomized self-checking bench for mem_access_unit with an arithmetic reference model.
module tb_mem_access_unit;
    import mem_access_unit_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        mem_read_flag, mem_write_flag, mem_sign_flag;
    logic [3:0]  mem_sel;
    logic [31:0] mem_write_data, mem_addr;
    logic [31:0] load_data;
    logic        load_valid, stall_req, misalign_exc, bus_err_exc;

    int          n_vec = 0;
    int          n_err = 0;
    logic [31:0] exp_load = '0;

    always #5 clk = ~clk;

    mem_access_unit_if bus ();

    mem_access_unit #(
        .DATA_WIDTH     (32),
        .ADDR_WIDTH     (32),
        .TIMEOUT_CYCLES (4)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .mem_read_flag  (mem_read_flag),
        .mem_write_flag (mem_write_flag),
        .mem_sign_flag  (mem_sign_flag),
        .mem_sel        (mem_sel),
        .mem_write_data (mem_write_data),
        .mem_addr       (mem_addr),
        .ram            (bus),
        .load_data      (load_data),
        .load_valid     (load_valid),
        .stall_req      (stall_req),
        .misalign_exc   (misalign_exc),
        .bus_err_exc    (bus_err_exc)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int sel_bytes(input logic [3:0] sel);
        case (sel)
            4'b0001: return 1;
            4'b0011: return 2;
            4'b1111: return 4;
            default: return 0;
        endcase
    endfunction

    function automatic logic [3:0] m_be(input int n, input logic [31:0] addr);
        return 4'(((1 << n) - 1) << (addr % 4));
    endfunction

    function automatic logic [31:0] m_wdata(input int n, input logic [31:0] d);
        logic [31:0] r;
        r = '0;
        for (int i = 0; i < 4; i++) r[8*i +: 8] = d[8*(i % n) +: 8];
        return r;
    endfunction

    function automatic logic [31:0] m_load(input int n, input logic sg, input logic [31:0] addr,
                                           input logic [31:0] rd);
        longint v;
        v = (longint'(rd) >> (8 * (addr % 4))) & ((longint'(1) << (8 * n)) - 1);
        if (sg && n < 4 && v >= (longint'(1) << (8 * n - 1))) v = v - (longint'(1) << (8 * n));
        return 32'(v);
    endfunction

    task automatic clear_inputs();
        mem_read_flag  = 1'b0;
        mem_write_flag = 1'b0;
        mem_sign_flag  = 1'b0;
        mem_sel        = 4'b0000;
        mem_write_data = '0;
        mem_addr       = '0;
    endtask

    // Entered and left at posedge+1 with the DUT in IDLE.
    task automatic access(input logic rd, input logic wr, input logic sg, input logic [3:0] sel,
                          input logic [31:0] wd, input logic [31:0] addr, input int ack_dly,
                          input logic [31:0] rdata);
        int   n;
        logic valid, mis;
        int   stalls;
        n      = sel_bytes(sel);
        valid  = (rd || wr) && n != 0;
        mis    = valid && ((addr % n) != 0);
        stalls = 0;
        mem_read_flag  = rd;
        mem_write_flag = wr;
        mem_sign_flag  = sg;
        mem_sel        = sel;
        mem_write_data = wd;
        mem_addr       = addr;
        @(negedge clk);
        check("stall_present", 32'(stall_req), 32'(valid && !mis));
        if (stall_req) stalls++;
        if (!valid || mis) begin
            @(posedge clk); #1;
            clear_inputs();
            check("misalign_exc", 32'(misalign_exc), 32'(mis));
            check("req_no_access", 32'(bus.ram_req), 32'd0);
            @(posedge clk); #1;
            check("misalign_pulse_end", 32'(misalign_exc), 32'd0);
            check("load_hold_noaccess", load_data, exp_load);
            return;
        end
        for (int k = 0; k <= ack_dly; k++) begin
            @(posedge clk); #1;
            bus.ram_ack   = (k == ack_dly);
            bus.ram_rdata = (k == ack_dly) ? rdata : $urandom;
            check("ram_req", 32'(bus.ram_req), 32'd1);
            check("ram_we", 32'(bus.ram_we), 32'(wr));
            check("ram_addr", bus.ram_addr, addr & 32'hFFFF_FFFC);
            check("ram_be", 32'(bus.ram_be), 32'(m_be(n, addr)));
            check("ram_wdata", bus.ram_wdata, m_wdata(n, wd));
            check("stall_req", 32'(stall_req), 32'd1);
            stalls++;
        end
        @(posedge clk); #1;
        bus.ram_ack = 1'b0;
        if (!wr) exp_load = m_load(n, sg, addr, rdata);
        check("done_req", 32'(bus.ram_req), 32'd0);
        check("done_stall", 32'(stall_req), 32'd0);
        check("load_valid", 32'(load_valid), 32'(!wr));
        check("load_data", load_data, exp_load);
        check("bus_err_exc", 32'(bus_err_exc), 32'd0);
        check("latency", 32'(stalls + 1), 32'(ack_dly + 3));
        @(posedge clk); #1;
        clear_inputs();
        bus.ram_ack   = 1'($urandom % 2);
        bus.ram_rdata = $urandom;
        check("no_retrigger", 32'(bus.ram_req), 32'd0);
        check("load_valid_end", 32'(load_valid), 32'd0);
        @(posedge clk); #1;
        bus.ram_ack = 1'b0;
        check("stray_ack", 32'(bus.ram_req) | 32'(load_valid) | 32'(stall_req), 32'd0);
        check("load_hold", load_data, exp_load);
    endtask

    logic [3:0] sels [4];

    initial begin
        sels = '{MEM_SEL_NONE, MEM_SEL_BYTE, MEM_SEL_HALF, MEM_SEL_WORD};
        rst_n         = 1'b0;
        bus.ram_ack   = 1'b0;
        bus.ram_rdata = '0;
        clear_inputs();
        #12;
        check("rst_req", 32'(bus.ram_req), 32'd0);
        check("rst_outs", load_data | 32'(load_valid) | 32'(stall_req) | 32'(misalign_exc)
              | 32'(bus_err_exc) | bus.ram_addr | bus.ram_wdata | 32'(bus.ram_be), 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        access(1'b0, 1'b1, 1'b0, MEM_SEL_WORD, 32'hDEADBEEF, 32'h100, 1, 32'h0);
        access(1'b0, 1'b1, 1'b0, MEM_SEL_BYTE, 32'h0000005A, 32'h203, 0, 32'h0);
        access(1'b1, 1'b0, 1'b1, MEM_SEL_BYTE, 32'h0, 32'h101, 0, 32'h0000_8000);
        check("lb_signed_const", load_data, 32'hFFFF_FF80);
        access(1'b1, 1'b0, 1'b0, MEM_SEL_BYTE, 32'h0, 32'h101, 0, 32'h0000_8000);
        check("lbu_const", load_data, 32'h0000_0080);
        access(1'b1, 1'b0, 1'b1, MEM_SEL_HALF, 32'h0, 32'h102, 0, 32'h8001_0000);
        check("lh_const", load_data, 32'hFFFF_8001);
        access(1'b1, 1'b0, 1'b1, MEM_SEL_HALF, 32'h0, 32'h103, 0, 32'h0);
        access(1'b1, 1'b1, 1'b0, MEM_SEL_NONE, 32'h1234, 32'h40, 0, 32'h0);
        access(1'b1, 1'b1, 1'b0, MEM_SEL_HALF, 32'hCAFE_BABE, 32'h42, 2, 32'h1111_2222);

        // Reset while a load is outstanding.
        mem_read_flag = 1'b1; mem_sel = MEM_SEL_WORD; mem_addr = 32'h300;
        @(posedge clk); #1;
        check("req_before_rst", 32'(bus.ram_req), 32'd1);
        rst_n = 1'b0;
        #1;
        check("rst_mid_req", 32'(bus.ram_req), 32'd0);
        check("rst_mid_outs", load_data | 32'(load_valid) | 32'(stall_req) | bus.ram_addr
              | 32'(bus.ram_be) | 32'(bus.ram_we), 32'd0);
        clear_inputs();
        exp_load = '0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        access(1'b1, 1'b0, 1'b0, MEM_SEL_WORD, 32'h0, 32'h304, 1, 32'h89AB_CDEF);
        check("lw_after_rst", load_data, 32'h89AB_CDEF);

`ifdef MEM_TIMEOUT_EN
        mem_read_flag = 1'b1; mem_sel = MEM_SEL_WORD; mem_addr = 32'h400;
        for (int k = 0; k < 4; k++) begin
            @(posedge clk); #1;
            check("tmo_req", 32'(bus.ram_req), 32'd1);
            check("tmo_no_err", 32'(bus_err_exc), 32'd0);
        end
        @(posedge clk); #1;
        exp_load = '0;
        check("tmo_bus_err", 32'(bus_err_exc), 32'd1);
        check("tmo_req_drop", 32'(bus.ram_req), 32'd0);
        check("tmo_no_valid", 32'(load_valid), 32'd0);
        check("tmo_load_zero", load_data, exp_load);
        @(posedge clk); #1;
        clear_inputs();
        check("tmo_err_pulse", 32'(bus_err_exc), 32'd0);
        check("tmo_idle", 32'(bus.ram_req), 32'd0);
        @(posedge clk); #1;
`endif

        for (int i = 0; i < 150; i++) begin
            access(1'($urandom % 2), 1'($urandom % 3 == 0), 1'($urandom % 2), sels[$urandom % 4],
                   $urandom, $urandom, int'($urandom % 4), $urandom);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
